aes_128: RTL and testbench



---
 rtl/aes_128.sv | 150 +++++++++++++++
 tb/tb_aes_128.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128.sv
// aes_128: iterative AES-128 encryption core.
// Each clock runs one cipher round. The round key is expanded on the fly
// alongside the state, so no key schedule storage is needed. Reset loads
// the operands and performs the initial AddRoundKey.
module aes_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         done
);

    logic [127:0] state;
    logic [127:0] rkey;
    logic [3:0]   round;

    logic [127:0] next_rkey;
    logic [127:0] sb_sr;
    logic [127:0] mid_state;
    logic [127:0] last_state;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // The S-box is the multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte 4c+r lives at bits [127-8*(4c+r) -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t ^ {rc, 24'h000000};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round datapath: next round key plus the full and final-round state updates.
    always_comb begin
        next_rkey  = key_step(rkey, rcon(round));
        sb_sr      = shift_rows(sub_bytes(state));
        mid_state  = mix_columns(sb_sr) ^ next_rkey;
        last_state = sb_sr ^ next_rkey;
    end

    // Load on reset, then one round per edge until round 10 publishes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= plain_text ^ key;
            rkey  <= key;
            round <= 4'd1;
            out   <= '0;
            done  <= 1'b0;
        end else if (round >= 4'd1 && round <= 4'd10) begin
            rkey  <= next_rkey;
            round <= round + 4'd1;
            if (round == 4'd10) begin
                state <= last_state;
                out   <= last_state;
                done  <= 1'b1;
            end else begin
                state <= mid_state;
            end
        end
    end

endmodule

// File: tb/tb_aes_128.sv
// tb_aes_128: scoreboard bench for the iterative AES-128 core.
// Expected ciphertexts come from known-answer constants or from a
// byte-array reference cipher; a monitor pops them when done rises.
module tb_aes_128;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic [127:0] out;
    logic         done;

    int nChecks = 0;
    int nPass   = 0;

    logic [127:0] expQ[$];
    logic [7:0]   sboxTab[256];
    logic         prevDone = 1'b0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KF_KEY = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] KF_PT  = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] KF_CT  = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_128 dut (
        .clk        (clk),
        .rst        (rst),
        .plain_text (plain_text),
        .key        (key),
        .out        (out),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Builds the S-box by searching for each inverse, then applying the affine map.
    task automatic buildSbox();
        logic [7:0] xb, cb, inv, s, c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                cb = c[7:0];
                if (refMul(xb, cb) == 8'h01) inv = cb;
            end
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sboxTab[x] = s;
        end
    endtask

    // Textbook cipher: full 44-word key schedule, 16-byte state array.
    function automatic logic [127:0] refEncrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w[44];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sboxTab[tmp[31:24]], sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc = refMul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sboxTab[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int rr = 0; rr < 4; rr++)
                        t[4*c + rr] = s[4*((c + rr) % 4) + rr];
                for (int i = 0; i < 16; i++) s[i] = t[i];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = refMul(a0, 8'h02) ^ refMul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ refMul(a1, 8'h02) ^ refMul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ refMul(a2, 8'h02) ^ refMul(a3, 8'h03);
                        s[4*c+3] = refMul(a0, 8'h03) ^ a1 ^ a2 ^ refMul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4*c + rr] = s[4*c + rr] ^ w[4*r + c][31 - 8*rr -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One edge with rst high; outputs must read as cleared afterwards.
    task automatic loadOperands(input logic [127:0] pt, input logic [127:0] k);
        rst        = 1'b1;
        plain_text = pt;
        key        = k;
        step();
        checkOutput("reset_out", out, 128'h0);
        checkOutput("reset_done", {127'h0, done}, 128'h0);
    endtask

    // Releases rst and runs ten round edges while scrambling the inputs.
    task automatic releaseAndRun(input logic [127:0] exp);
        rst = 1'b0;
        expQ.push_back(exp);
        for (int i = 1; i <= 10; i++) begin
            plain_text = rand128();
            key        = rand128();
            step();
            checkOutput($sformatf("done_edge%0d", i), {127'h0, done}, (i == 10) ? 128'h1 : 128'h0);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
        loadOperands(pt, k);
        releaseAndRun(exp);
    endtask

    // Monitor: every rising done consumes the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1 && prevDone !== 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_done: got done=1 with out=%h expected no pending block", out);
            end else begin
                checkOutput("ciphertext", out, expQ.pop_front());
            end
        end
        prevDone <= done;
    end

    // Stimulus: known answers, random blocks, resampling, abort and hold.
    initial begin
        logic [127:0] pt, k, pt2, k2, expB;
        rst        = 1'b1;
        plain_text = '0;
        key        = '0;
        buildSbox();

        applyStimulus(C1_PT, C1_KEY, C1_CT);
        applyStimulus(KF_PT, KF_KEY, KF_CT);
        applyStimulus(B_PT, B_KEY, B_CT);

        for (int n = 0; n < 6; n++) begin
            pt = rand128();
            k  = rand128();
            applyStimulus(pt, k, refEncrypt(pt, k));
        end

        loadOperands(KF_PT, KF_KEY);
        loadOperands(KF_PT, KF_KEY);
        applyStimulus(C1_PT, C1_KEY, C1_CT);

        for (int n = 0; n < 4; n++) loadOperands(rand128(), rand128());

        pt  = rand128();
        k   = rand128();
        pt2 = rand128();
        k2  = rand128();
        expB = refEncrypt(pt2, k2);
        loadOperands(pt, k);
        rst = 1'b0;
        expQ.push_back(refEncrypt(pt, k));
        for (int i = 0; i < 5; i++) step();
        checkOutput("abort_pre_done", {127'h0, done}, 128'h0);
        // The aborted block never completes, so its expectation is withdrawn.
        void'(expQ.pop_back());
        rst        = 1'b1;
        plain_text = pt2;
        key        = k2;
        step();
        checkOutput("abort_out", out, 128'h0);
        checkOutput("abort_done", {127'h0, done}, 128'h0);
        releaseAndRun(expB);

        for (int i = 0; i < 20; i++) begin
            plain_text = rand128();
            key        = rand128();
            step();
            checkOutput("hold_out", out, expB);
            checkOutput("hold_done", {127'h0, done}, 128'h1);
        end

        for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
        checkOutput("scoreboard_drained", 128'(expQ.size()), 128'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
